branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand width in bits.
REQ-002 SHALL have parameter PCW, default 64, the PC and target width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the request handshake.
REQ-006 SHALL have ports rs1 and rs2, input, WIDTH bits each, the compare operands.
REQ-007 SHALL have port funct3, input, 3 bits, the compare mode; is_jump, input, 1 bit, unconditional taken.
REQ-008 SHALL have ports pred_taken (input, 1), pc (input, PCW), target (input, PCW).
REQ-009 SHALL have ports out_valid (input-side result valid, output, 1) and out_ready (input, 1).
REQ-010 SHALL have ports taken (output, 1), mispredict (output, 1), illegal (output, 1), redirect_pc (output, PCW).
REQ-011 SHALL have port flush, input, 1 bit, which discards all buffered entries.

Function
REQ-012 SHALL decode funct3 as follows: 000 equal, 001 not-equal, 100 signed less-than, 101 signed greater-or-equal, 110 unsigned less-than, 111 unsigned greater-or-equal.
REQ-013 SHALL set taken to 0 and illegal to 1 when funct3 is 010 or 011 and is_jump is 0.
REQ-014 SHALL set taken to 1 and illegal to 0 when is_jump is 1, regardless of funct3.
REQ-015 SHALL set mispredict to (taken XOR pred_taken).
REQ-016 SHALL set redirect_pc to target when taken is 1, otherwise to pc+4 modulo 2^PCW.
REQ-017 SHALL compute the result at acceptance and store it in a 2-entry in-order FIFO (states EMPTY, ONE, FULL).
REQ-018 SHALL accept an input when in_valid and in_ready are both 1.
REQ-019 SHALL drive in_ready as 1 unless the FIFO is FULL, combinationally independent of out_ready.
REQ-020 SHALL present the head entry on the outputs with out_valid 1 whenever the FIFO is non-empty; latency is 1 cycle from acceptance.
REQ-021 SHALL keep the head entry and out_valid stable until out_valid and out_ready are both 1.
REQ-022 SHALL, when accepting and popping in the same cycle, leave the occupancy unchanged and preserve order.
REQ-023 SHALL empty the FIFO on the next edge when flush is 1, dropping any same-cycle input and ignoring the same-cycle pop.
REQ-024 SHALL hold taken, mispredict, illegal and redirect_pc at 0 whenever out_valid is 0.

Reset
REQ-025 SHALL, while resetn is 0, force the FIFO to EMPTY, out_valid to 0, in_ready to 1, all result outputs to 0, and any counters to 0.
REQ-026 SHALL, when resetn asserts mid-operation, discard all entries immediately without waiting for a clock edge.
REQ-027 SHALL accept new input on the first rising edge after resetn deasserts.

Configuration
REQ-028 SHALL, with macro BRANCH_STATS_EN defined, add 32-bit output ports br_cnt and mis_cnt, wrapping modulo 2^32.
REQ-029 SHALL increment br_cnt on each output handshake, and mis_cnt on each output handshake that carries mispredict 1.
REQ-030 SHALL leave both counters unchanged in a flush cycle.
REQ-031 SHALL, without BRANCH_STATS_EN, omit both ports and all counter logic, with all other behaviour identical.

Verification
REQ-032 SHALL cover signed versus unsigned compare: WIDTH=64, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1.
  - funct3=100 -> taken=1.
  - funct3=110 -> taken=0.
  - With pred_taken=0, funct3=100 -> mispredict=1 and redirect_pc=target.
REQ-033 SHALL cover backpressure: out_ready=0 and three back-to-back requests.
  - in_ready=0 after two accepts; the third request is held.
  - With out_ready=1 for three cycles, results emerge in order with no duplicates.
REQ-034 SHALL cover flush: flush=1 with the FIFO FULL and in_valid=1 -> the next cycle has out_valid=0 and in_ready=1, and no entry survives.
REQ-035 SHALL cover illegal and jump decode with pc=0xFFFF_FFFF_FFFF_FFFC.
  - funct3=011 -> illegal=1, taken=0, redirect_pc=0.
  - is_jump=1 -> taken=1, redirect_pc=target.
REQ-036 SHALL cover asynchronous reset: resetn pulsed low between edges with the FIFO FULL -> out_valid falls without a clock edge, and counters read 0.
REQ-037 SHALL cover counters, with BRANCH_STATS_EN defined: five handshakes, two of them mispredicted -> br_cnt=5 and mis_cnt=2; with br_cnt preset to 0xFFFF_FFFF, one further handshake -> br_cnt=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, resolves taken/mispredict/redirect and buffers results in a 2-entry FIFO.
// Optional BRANCH_STATS_EN adds wrapping branch and mispredict counters.
module branch_resolve_unit #(
  parameter int WIDTH = 64,
  parameter int PCW   = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       funct3,
  input  logic             is_jump,
  input  logic             pred_taken,
  input  logic [PCW-1:0]   pc,
  input  logic [PCW-1:0]   target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic [PCW-1:0]   redirect_pc,
  input  logic             flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mis_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic           taken;
    logic           mis;
    logic           ill;
    logic [PCW-1:0] rpc;
  } entry_t;

  function automatic entry_t resolve(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] f3, input logic jmp, input logic pred,
                                     input logic [PCW-1:0] pc_i, input logic [PCW-1:0] tgt);
    entry_t e;
    logic   tk;
    logic   ill;
    tk  = 1'b0;
    ill = 1'b0;
    if (jmp) begin
      tk = 1'b1;
    end else begin
      case (f3)
        3'b000:  tk = (a == b);
        3'b001:  tk = (a != b);
        3'b100:  tk = ($signed(a) <  $signed(b));
        3'b101:  tk = ($signed(a) >= $signed(b));
        3'b110:  tk = (a <  b);
        3'b111:  tk = (a >= b);
        default: ill = 1'b1;
      endcase
    end
    e.taken = tk;
    e.mis   = tk ^ pred;
    e.ill   = ill;
    e.rpc   = tk ? tgt : (pc_i + PCW'(3'd4));
    return e;
  endfunction

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   push_s, pop_s;
  entry_t res_s;

  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;
  assign res_s  = resolve(rs1, rs2, funct3, is_jump, pred_taken, pc, target);

  // Next-state for the FIFO; an empty head is kept all-zero so outputs read 0 when invalid.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d = ONE;
            head_d  = res_s;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_d = res_s;
          end else if (push_s) begin
            state_d = FULL;
            tail_d  = res_s;
          end else if (pop_s) begin
            state_d = EMPTY;
            head_d  = '0;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            state_d = ONE;
            head_d  = tail_q;
            tail_d  = '0;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // FIFO state and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign taken       = head_q.taken;
  assign mispredict  = head_q.mis;
  assign illegal     = head_q.ill;
  assign redirect_pc = head_q.rpc;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Counters advance on output handshakes only; a flush cycle freezes them.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (pop_s && !flush) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (head_q.mis) begin
        mis_cnt_d = mis_cnt_q + 32'd1;
      end else begin
        mis_cnt_d = mis_cnt_q;
      end
    end else begin
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_cnt_q  <= 32'd0;
      mis_cnt_q <= 32'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default 64-bit configuration).
module tb_branch_resolve_unit;
  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [2:0]  funct3;
  logic        is_jump;
  logic        pred_taken;
  logic [63:0] pc;
  logic [63:0] target;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic        mispredict;
  logic        illegal;
  logic [63:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;
`endif

  int total_cnt;
  int bad_cnt;

  branch_resolve_unit #(.WIDTH(64), .PCW(64)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .funct3(funct3), .is_jump(is_jump),
    .pred_taken(pred_taken), .pc(pc), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .illegal(illegal), .redirect_pc(redirect_pc),
    .flush(flush)
`ifdef BRANCH_STATS_EN
    , .br_cnt(br_cnt), .mis_cnt(mis_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                         input logic jmp, input logic pred, input logic [63:0] p, input logic [63:0] t);
    in_valid   = 1'b1;
    rs1        = a;
    rs2        = b;
    funct3     = f3;
    is_jump    = jmp;
    pred_taken = pred;
    pc         = p;
    target     = t;
  endtask

  // One request accepted on the next edge, then sampled on the following falling edge.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                       input logic jmp, input logic pred, input logic [63:0] p, input logic [63:0] t);
    set_req(a, b, f3, jmp, pred, p, t);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic tk, input logic mp, input logic il,
                            input logic [63:0] rpc);
    check_val({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    check_val({tag, ".taken"}, {63'd0, taken}, {63'd0, tk});
    check_val({tag, ".mis"},   {63'd0, mispredict}, {63'd0, mp});
    check_val({tag, ".ill"},   {63'd0, illegal}, {63'd0, il});
    check_val({tag, ".rpc"},   redirect_pc, rpc);
  endtask

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TGT  = 64'h0000_0000_0000_2000;
  localparam logic [63:0] PCA  = 64'h0000_0000_0000_1000;

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    resetn     = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b0;
    rs1        = 64'd0;
    rs2        = 64'd0;
    funct3     = 3'd0;
    is_jump    = 1'b0;
    pred_taken = 1'b0;
    pc         = 64'd0;
    target     = 64'd0;

    @(negedge clk);
    @(negedge clk);
    check_val("rst.valid", {63'd0, out_valid}, 64'd0);
    check_val("rst.ready", {63'd0, in_ready}, 64'd1);
    check_val("rst.taken", {63'd0, taken}, 64'd0);
    check_val("rst.rpc", redirect_pc, 64'd0);
`ifdef BRANCH_STATS_EN
    check_val("rst.br", {32'd0, br_cnt}, 64'd0);
`endif
    resetn = 1'b1;

    // Signed vs unsigned compare of -1 against 1.
    apply(ALL1, 64'd1, 3'b100, 1'b0, 1'b0, PCA, TGT);
    expect_out("slt", 1'b1, 1'b1, 1'b0, TGT);
    apply(ALL1, 64'd1, 3'b110, 1'b0, 1'b0, PCA, TGT);
    expect_out("sltu", 1'b0, 1'b0, 1'b0, 64'h1004);
    apply(ALL1, 64'd1, 3'b101, 1'b0, 1'b1, PCA, TGT);
    expect_out("sge", 1'b0, 1'b1, 1'b0, 64'h1004);
    apply(ALL1, 64'd1, 3'b111, 1'b0, 1'b1, PCA, TGT);
    expect_out("sgeu", 1'b1, 1'b0, 1'b0, TGT);
    apply(64'd5, 64'd5, 3'b000, 1'b0, 1'b1, PCA, TGT);
    expect_out("beq", 1'b1, 1'b0, 1'b0, TGT);
    apply(64'd5, 64'd5, 3'b001, 1'b0, 1'b1, PCA, TGT);
    expect_out("bne", 1'b0, 1'b1, 1'b0, 64'h1004);

    // Illegal decode and jump at the top of the PC space.
    apply(64'd1, 64'd2, 3'b011, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, TGT);
    expect_out("ill", 1'b0, 1'b0, 1'b1, 64'd0);
    apply(64'd1, 64'd2, 3'b011, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_0000_0010);
    expect_out("jmp", 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0010);
    @(posedge clk);
    @(negedge clk);
    check_val("drain.valid", {63'd0, out_valid}, 64'd0);
    check_val("drain.rpc", redirect_pc, 64'd0);

    // Backpressure: three back-to-back not-taken requests, distinct PCs.
    out_ready = 1'b0;
    set_req(64'd1, 64'd2, 3'b000, 1'b0, 1'b0, 64'h100, TGT);
    @(posedge clk);
    @(negedge clk);
    check_val("bp.ready1", {63'd0, in_ready}, 64'd1);
    set_req(64'd1, 64'd2, 3'b000, 1'b0, 1'b0, 64'h200, TGT);
    @(posedge clk);
    @(negedge clk);
    check_val("bp.ready2", {63'd0, in_ready}, 64'd0);
    check_val("bp.head2", redirect_pc, 64'h104);
    set_req(64'd1, 64'd2, 3'b000, 1'b0, 1'b0, 64'h300, TGT);
    @(posedge clk);
    @(negedge clk);
    check_val("bp.held", {63'd0, in_ready}, 64'd0);
    check_val("bp.headheld", redirect_pc, 64'h104);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp.pop1", redirect_pc, 64'h204);
    check_val("bp.ready3", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp.pop2", redirect_pc, 64'h304);
    check_val("bp.v2", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check_val("bp.empty", {63'd0, out_valid}, 64'd0);

    // Flush with FIFO full and a same-cycle input.
    out_ready = 1'b0;
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b0, 64'h400, TGT);
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b0, 64'h500, TGT);
    check_val("fl.full", {63'd0, in_ready}, 64'd0);
    set_req(64'd1, 64'd1, 3'b000, 1'b0, 1'b0, 64'h600, TGT);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("fl.valid", {63'd0, out_valid}, 64'd0);
    check_val("fl.ready", {63'd0, in_ready}, 64'd1);
    check_val("fl.taken", {63'd0, taken}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("fl.none", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges with FIFO full.
    out_ready = 1'b0;
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b1, 64'h700, TGT);
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b1, 64'h800, TGT);
    check_val("ar.prevalid", {63'd0, out_valid}, 64'd1);
    #1 resetn = 1'b0;
    #1;
    check_val("ar.valid", {63'd0, out_valid}, 64'd0);
    check_val("ar.ready", {63'd0, in_ready}, 64'd1);
    check_val("ar.mis", {63'd0, mispredict}, 64'd0);
`ifdef BRANCH_STATS_EN
    check_val("ar.br", {32'd0, br_cnt}, 64'd0);
    check_val("ar.miscnt", {32'd0, mis_cnt}, 64'd0);
`endif
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    set_req(64'd3, 64'd3, 3'b000, 1'b0, 1'b0, 64'h900, TGT);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("ar.first", 1'b1, 1'b1, 1'b0, TGT);
    @(posedge clk);
    @(negedge clk);

`ifdef BRANCH_STATS_EN
    // Counter run: restart from reset, five handshakes with two mispredicts.
    resetn = 1'b0;
    #1 resetn = 1'b1;
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b1, PCA, TGT);
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b0, PCA, TGT);
    apply(64'd1, 64'd2, 3'b000, 1'b0, 1'b0, PCA, TGT);
    apply(64'd1, 64'd2, 3'b000, 1'b0, 1'b1, PCA, TGT);
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b1, PCA, TGT);
    @(posedge clk);
    @(negedge clk);
    check_val("cnt.br", {32'd0, br_cnt}, 64'd5);
    check_val("cnt.mis", {32'd0, mis_cnt}, 64'd2);
    dut.br_cnt_q = 32'hFFFF_FFFF;
    apply(64'd1, 64'd1, 3'b000, 1'b0, 1'b1, PCA, TGT);
    @(posedge clk);
    @(negedge clk);
    check_val("cnt.wrap", {32'd0, br_cnt}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
